// File: rtl/axis_serializer.sv
// Wide-to-narrow stream converter: one DATA_NB*DATA_WIDTH word out as DATA_NB sub-words, lowest first.
// Latency: sub-word 0 is registered on down_* one cycle after the input handshake; one sub-word per clock after that.
// Backpressure: outputs and index hold while down_ready is low; up_ready only opens when the last sub-word is leaving or the block is empty.
module axis_serializer #(
   parameter int DATA_NB    = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_NB*DATA_WIDTH-1:0] up_data,
   input  logic                          up_valid,
   output logic                          up_ready,
   input  logic                          up_last,
   output logic [DATA_WIDTH-1:0]         down_data,
   output logic                          down_valid,
   input  logic                          down_ready,
   output logic                          down_last
);

   localparam int IW = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_NB - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                             state;
   state_t                             state_nxt;
   logic [DATA_NB-1:0][DATA_WIDTH-1:0] word_q;
   logic                               last_q;
   logic [IW-1:0]                      idx;
   logic [IW-1:0]                      idx_inc;
   logic                               at_last;
   logic                               load;
   logic                               advance;
   logic                               finish;

   // down_valid comes straight from the state flop, so it is registered.
   assign down_valid = (state == SHIFT);
   assign at_last    = (idx == IDX_LAST);
   // Depends only on rst, state, idx and down_ready: no path from up_valid.
   assign up_ready   = !rst && (!down_valid || (down_ready && at_last));

   // Handshake decode and next-state selection.
   always_comb begin
      idx_inc   = idx + 1'b1;
      load      = up_valid && up_ready;
      advance   = down_valid && down_ready && !at_last;
      finish    = down_valid && down_ready && at_last;
      state_nxt = state;
      if (load) begin
         state_nxt = SHIFT;
      end else if (finish) begin
         state_nxt = EMPTY;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Word buffer, sub-word index and registered output sub-word.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q    <= '0;
         last_q    <= 1'b0;
         idx       <= '0;
         down_data <= '0;
         down_last <= 1'b0;
      end else if (load) begin
         // A load on the final consumed sub-word chains the next word with no bubble.
         word_q    <= up_data;
         last_q    <= up_last;
         idx       <= '0;
         down_data <= up_data[DATA_WIDTH-1:0];
         down_last <= up_last && (DATA_NB == 1);
      end else if (advance) begin
         idx       <= idx_inc;
         down_data <= word_q[idx_inc];
         down_last <= last_q && (idx_inc == IDX_LAST);
      end else if (finish) begin
         down_last <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_serializer.sv
// Directed bench for axis_serializer (DATA_NB=3, DATA_WIDTH=8).
// Upstream words come from a queue; every consumed sub-word is logged for ordered checking.
// Ends with a serializer-to-narrow-stream reassembly check under random down_ready.
module tb_axis_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] up_data;
   logic        up_valid;
   logic        up_ready;
   logic        up_last;
   logic [7:0]  down_data;
   logic        down_valid;
   logic        down_ready;
   logic        down_last;

   int n_cmp = 0;
   int n_bad = 0;

   logic [24:0] up_q[$];   // {last, data}
   logic [8:0]  outs[$];   // {last, byte}
   logic        ur_seen;

   axis_serializer #(.DATA_NB(3), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_last    (up_last),
      .down_data  (down_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_last  (down_last)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [23:0] d, input logic l);
      up_q.push_back({l, d});
   endtask

   // One clock: present queue head, capture handshakes, advance past the edge.
   task automatic cyc(input logic dr);
      logic       hs_up;
      logic       hs_dn;
      logic [8:0] dn;
      down_ready = dr;
      if (up_q.size() > 0) begin
         up_valid = 1'b1;
         up_data  = up_q[0][23:0];
         up_last  = up_q[0][24];
      end else begin
         up_valid = 1'b0;
         up_data  = '0;
         up_last  = 1'b0;
      end
      #1;
      ur_seen = up_ready;
      hs_up   = up_valid && up_ready;
      hs_dn   = down_valid && down_ready;
      dn      = {down_last, down_data};
      @(posedge clk);
      #1;
      if (hs_up) void'(up_q.pop_front());
      if (hs_dn) outs.push_back(dn);
   endtask

   task automatic drain(input int maxc, input bit rnd);
      int n = 0;
      while ((up_q.size() > 0 || down_valid) && n < maxc) begin
         cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
      if (n >= maxc) check_eq("drain_timeout", 32'(n), 32'(0));
   endtask

   task automatic check_outs(input string tag, input logic [8:0] exp[$]);
      check_eq({tag, "_count"}, 32'(outs.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < outs.size(); i++)
         check_eq(tag, 32'(outs[i]), 32'(exp[i]));
   endtask

   initial begin
      logic [8:0] pattern;
      logic [8:0] exp_q[$];
      rst        = 1'b1;
      up_valid   = 1'b0;
      up_data    = '0;
      up_last    = 1'b0;
      down_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset holds outputs low and up_ready low even with up_valid high.
      push(24'h030201, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1);
         check_eq("rst_dvalid", 32'(down_valid), 32'(0));
         check_eq("rst_dlast",  32'(down_last),  32'(0));
         check_eq("rst_ddata",  32'(down_data),  32'(0));
         check_eq("rst_uready", 32'(ur_seen),    32'(0));
      end
      rst = 1'b0;
      cyc(1'b1);
      check_eq("first_load_data",  32'(down_data),  32'h01);
      check_eq("first_load_valid", 32'(down_valid), 32'(1));
      drain(20, 1'b0);
      check_outs("rst_word", '{9'h001, 9'h002, 9'h003});

      // Single word: 01,02,03 on the three cycles after the handshake.
      outs.delete();
      push(24'h030201, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1);
         check_eq("single_data",  32'(down_data),  32'(k + 1));
         check_eq("single_valid", 32'(down_valid), 32'(1));
         check_eq("single_last",  32'(down_last),  32'(0));
      end
      cyc(1'b1);
      check_eq("single_idle", 32'(down_valid), 32'(0));

      // Continuous stream: no bubble, up_ready opens every third cycle.
      outs.delete();
      pattern = 9'b001001001;
      push(24'h030201, 1'b0);
      push(24'h060504, 1'b0);
      push(24'h090807, 1'b0);
      for (int k = 0; k < 9; k++) begin
         cyc(1'b1);
         check_eq("cont_uready", 32'(ur_seen),    32'(pattern[k]));
         check_eq("cont_data",   32'(down_data),  32'(k + 1));
         check_eq("cont_valid",  32'(down_valid), 32'(1));
      end
      cyc(1'b1);
      check_eq("cont_idle", 32'(down_valid), 32'(0));

      // Backpressure while 05 is presented.
      outs.delete();
      push(24'h030201, 1'b0);
      push(24'h060504, 1'b0);
      push(24'h090807, 1'b0);
      repeat (5) cyc(1'b1);
      check_eq("bp_pre_data", 32'(down_data), 32'h05);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0);
         check_eq("bp_hold_data",  32'(down_data),  32'h05);
         check_eq("bp_hold_valid", 32'(down_valid), 32'(1));
         check_eq("bp_uready",     32'(ur_seen),    32'(0));
      end
      drain(30, 1'b0);
      check_outs("bp_seq", '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h009});

      // Last flag only with the final sub-word of the flagged word.
      outs.delete();
      push(24'h030201, 1'b0);
      push(24'h060504, 1'b1);
      push(24'h090807, 1'b0);
      drain(30, 1'b0);
      check_outs("last_seq", '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h106, 9'h007, 9'h008, 9'h009});

      // Reset mid-word discards the rest of the word.
      outs.delete();
      push(24'h030201, 1'b0);
      cyc(1'b1);
      cyc(1'b1);
      check_eq("midrst_pre", 32'(down_data), 32'h02);
      rst = 1'b1;
      cyc(1'b1);
      check_eq("midrst_valid", 32'(down_valid), 32'(0));
      rst = 1'b0;
      push(24'h0C0B0A, 1'b0);
      drain(20, 1'b0);
      check_outs("midrst_seq", '{9'h001, 9'h002, 9'h00A, 9'h00B, 9'h00C});

      // Loopback: bytes 01..FF reassembled into 3-byte words under random down_ready.
      outs.delete();
      for (int i = 0; i < 85; i++)
         push({8'(3 * i + 3), 8'(3 * i + 2), 8'(3 * i + 1)}, (i % 4) == 3);
      drain(3000, 1'b1);
      check_eq("loop_count", 32'(outs.size()), 32'(255));
      for (int i = 0; i < 85 && outs.size() >= 255; i++) begin
         logic [26:0] got_w;
         logic [26:0] exp_w;
         for (int j = 0; j < 3; j++) begin
            got_w[j*9 +: 9] = outs[3*i + j];
            exp_w[j*9 +: 9] = {(j == 2) && ((i % 4) == 3), 8'(3 * i + j + 1)};
         end
         check_eq("loop_word", 32'(got_w), 32'(exp_w));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
